// File: rtl/btn_bit_source_pkg.sv
// Shared definitions for the two-button bit-entry source: FSM state encoding,
// default debounce length and a small button-decoding helper.
package btn_bit_source_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    localparam int DB_CYCLES_DEFAULT = 16;

    function automatic logic exactly_one(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one raw push-button; both stages clear on reset.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

endmodule

// File: rtl/btn_bit_source.sv
// Debounces two push-buttons into a stream of accepted bits: one strobe per
// press, with a 4-bit history of the most recent bits (newest in bit 0).
module btn_bit_source
    import btn_bit_source_pkg::*;
#(
    parameter int DB_CYCLES = btn_bit_source_pkg::DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn0,
    output logic       bit_valid,
    output logic       bit_val,
    output logic [3:0] hist,
    output logic       busy
);

    localparam int                CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s0;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cand;
    logic             cand_hi;
    logic             other_hi;

    btn_sync u_sync1 (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn1),
        .sync (s1)
    );

    btn_sync u_sync0 (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn0),
        .sync (s0)
    );

    assign cand_hi  = cand ? s1 : s0;
    assign other_hi = cand ? s0 : s1;

    // busy is written alongside every state change so it always equals (state != IDLE)
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 1'b0;
            bit_valid <= 1'b0;
            bit_val   <= 1'b0;
            hist      <= 4'b0000;
            busy      <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (exactly_one(s1, s0)) begin
                        cand  <= s1;
                        cnt   <= '0;
                        state <= PRESS_DB;
                        busy  <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (cand_hi && !other_hi) begin
                        if (cnt == LAST) begin
                            state     <= HELD;
                            cnt       <= '0;
                            bit_valid <= 1'b1;
                            bit_val   <= cand;
                            hist      <= {hist[2:0], cand};
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                HELD: begin
                    if (!s1 && !s0) begin
                        state <= REL_DB;
                        cnt   <= '0;
                    end
                end
                REL_DB: begin
                    if (s1 || s0) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_bit_source.sv
// Bench for btn_bit_source (DB_CYCLES=4): directed segment table plus
// randomized button activity checked against a run-length reference model.
module tb_btn_bit_source;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic       btn1;
    logic       btn0;
    logic       bit_valid;
    logic       bit_val;
    logic [3:0] hist;
    logic       busy;

    int checks = 0;
    int errors = 0;

    btn_bit_source #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn1      (btn1),
        .btn0      (btn0),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .hist      (hist),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a press is accepted after DB+1 consecutive synchronised
    // samples showing only that button, starting while armed; rearming needs
    // DB+1 consecutive all-low samples.
    logic [1:0] m_sync1, m_sync2;
    bit         m_armed;
    int         m_run_len;
    bit         m_run_btn;
    int         m_rel_len;
    bit         m_valid;
    bit         m_acc[$];

    task automatic modelEdge(input logic r, input logic b1, input logic b0);
        logic [1:0] sample;
        if (r) begin
            m_sync1 = 2'b00;
            m_sync2 = 2'b00;
            m_armed = 1'b1;
            m_run_len = 0;
            m_rel_len = 0;
            m_valid = 1'b0;
            m_acc.delete();
            return;
        end
        sample  = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = {b1, b0};
        m_valid = 1'b0;
        if (m_armed) begin
            if (m_run_len == 0) begin
                if (sample == 2'b10 || sample == 2'b01) begin
                    m_run_btn = sample[1];
                    m_run_len = 1;
                end
            end else if (sample == (m_run_btn ? 2'b10 : 2'b01)) begin
                m_run_len++;
                if (m_run_len == DB + 1) begin
                    m_valid = 1'b1;
                    m_acc.push_back(m_run_btn);
                    m_armed = 1'b0;
                    m_rel_len = 0;
                    m_run_len = 0;
                end
            end else begin
                m_run_len = 0;
            end
        end else begin
            if (sample == 2'b00) begin
                m_rel_len++;
                if (m_rel_len == DB + 1) begin
                    m_armed = 1'b1;
                    m_run_len = 0;
                end
            end else begin
                m_rel_len = 0;
            end
        end
    endtask

    function automatic logic [6:0] modelOutputs();
        logic [3:0] h;
        logic       v;
        logic       b;
        int         n;
        n = m_acc.size();
        h = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (n > i) h[i] = m_acc[n-1-i];
        v = (n > 0) ? m_acc[n-1] : 1'b0;
        b = !m_armed || (m_run_len > 0);
        return {m_valid, v, h, b};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic b1, input logic b0);
        rst  = r;
        btn1 = b1;
        btn0 = b0;
        @(posedge clk);
        modelEdge(r, b1, b0);
        @(negedge clk);
        checkOutput("model {valid,val,hist,busy}",
                    {25'd0, bit_valid, bit_val, hist, busy},
                    {25'd0, modelOutputs()});
    endtask

    typedef struct {
        logic       rst;
        logic       b1;
        logic       b0;
        int         len;
        int         pulses;
        int         pulse_at;
        logic       val;
        logic [3:0] hist;
        int         busy_end;
        int         busy_low_at;
    } seg_t;

    seg_t tbl[$];

    task automatic addSeg(input logic r, input logic b1, input logic b0, input int len,
                          input int pulses, input int pulse_at, input logic val,
                          input logic [3:0] h, input int busy_end, input int busy_low_at);
        seg_t s;
        s.rst = r; s.b1 = b1; s.b0 = b0; s.len = len;
        s.pulses = pulses; s.pulse_at = pulse_at; s.val = val; s.hist = h;
        s.busy_end = busy_end; s.busy_low_at = busy_low_at;
        tbl.push_back(s);
    endtask

    initial begin
        rst  = 1'b1;
        btn1 = 1'b0;
        btn0 = 1'b0;

        // reset, single press with exact latency, release timing
        addSeg(1, 0, 0,  3, 0, 0, 0, 4'b0000,  0, 0);
        addSeg(0, 1, 0, 20, 1, 7, 1, 4'b0001,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 1, 4'b0001,  0, 7);
        // bouncing btn0, then a stable run
        for (int k = 0; k < 5; k++) begin
            addSeg(0, 0, 1, 2, 0, 0, 1, 4'b0001, -1, 0);
            addSeg(0, 0, 0, 1, 0, 0, 1, 4'b0001, -1, 0);
        end
        addSeg(0, 0, 1, 10, 1, 7, 0, 4'b0010,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 0, 4'b0010,  0, 7);
        // both buttons together, then btn1 alone
        addSeg(0, 1, 1, 10, 0, 0, 0, 4'b0010,  0, 1);
        addSeg(0, 1, 0, 10, 1, 7, 1, 4'b0101,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 1, 4'b0101,  0, 7);
        // sequence 1,1,0,1,0
        addSeg(0, 1, 0, 10, 1, 7, 1, 4'b1011,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 1, 4'b1011,  0, 7);
        addSeg(0, 1, 0, 10, 1, 7, 1, 4'b0111,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 1, 4'b0111,  0, 7);
        addSeg(0, 0, 1, 10, 1, 7, 0, 4'b1110,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 0, 4'b1110,  0, 7);
        addSeg(0, 1, 0, 10, 1, 7, 1, 4'b1101,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 1, 4'b1101,  0, 7);
        addSeg(0, 0, 1, 10, 1, 7, 0, 4'b1010,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 0, 4'b1010,  0, 7);
        // reset mid-debounce with counter at 2, button held through release
        addSeg(0, 1, 0,  5, 0, 0, 0, 4'b1010,  1, 0);
        addSeg(1, 1, 0,  1, 0, 0, 0, 4'b0000,  0, 1);
        addSeg(0, 1, 0, 10, 1, 7, 1, 4'b0001,  1, 0);
        addSeg(0, 0, 0, 10, 0, 0, 1, 4'b0001,  0, 7);

        for (int s = 0; s < tbl.size(); s++) begin
            int pulses;
            int first_pulse;
            int first_low;
            pulses = 0;
            first_pulse = 0;
            first_low = 0;
            for (int i = 1; i <= tbl[s].len; i++) begin
                applyStimulus(tbl[s].rst, tbl[s].b1, tbl[s].b0);
                if (bit_valid === 1'b1) begin
                    pulses++;
                    if (first_pulse == 0) first_pulse = i;
                end
                if (busy === 1'b0 && first_low == 0) first_low = i;
            end
            checkOutput($sformatf("seg%0d pulses", s), pulses, tbl[s].pulses);
            if (tbl[s].pulses > 0)
                checkOutput($sformatf("seg%0d pulse cycle", s), first_pulse, tbl[s].pulse_at);
            checkOutput($sformatf("seg%0d bit_val", s), {31'd0, bit_val}, {31'd0, tbl[s].val});
            checkOutput($sformatf("seg%0d hist", s), {28'd0, hist}, {28'd0, tbl[s].hist});
            if (tbl[s].busy_end >= 0)
                checkOutput($sformatf("seg%0d busy end", s), {31'd0, busy}, tbl[s].busy_end);
            if (tbl[s].busy_low_at > 0)
                checkOutput($sformatf("seg%0d busy low cycle", s), first_low, tbl[s].busy_low_at);
        end

        $display("[TB] directed segments done, starting random phase");

        for (int n = 0; n < 300; n++) begin
            int   len;
            logic r;
            logic [1:0] pat;
            r   = ($urandom_range(0, 24) == 0);
            pat = 2'($urandom_range(0, 3));
            len = r ? $urandom_range(1, 2) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                applyStimulus(r, pat[1], pat[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_bit_source.md
BTN_BIT_SOURCE -- requirements
Module: btn_bit_source

Interface
REQ-001 The block SHALL expose parameter DB_CYCLES, default 16, the number of consecutive stable synchronised cycles required to accept a press or a release; legal range 2..65535.
REQ-002 The block SHALL expose `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL expose `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL expose `btn1`, input, 1 bit: raw asynchronous push-button, active-high, meaning "enter bit 1".
REQ-005 The block SHALL expose `btn0`, input, 1 bit: raw asynchronous push-button, active-high, meaning "enter bit 0".
REQ-006 The block SHALL expose `bit_valid`, output, 1 bit: one-cycle strobe, one accepted bit per press.
REQ-007 The block SHALL expose `bit_val`, output, 1 bit: accepted bit value, qualified by `bit_valid`.
REQ-008 The block SHALL expose `hist`, output, 4 bits: the last four accepted bits, newest in bit 0.
REQ-009 The block SHALL expose `busy`, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 Each raw button SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-011 The FSM SHALL have exactly four states: IDLE, PRESS_DB, HELD and REL_DB.
REQ-012 In IDLE with exactly one synchronised button high, the FSM SHALL latch that button's bit as the candidate, clear the counter and enter PRESS_DB.
REQ-013 In IDLE with both synchronised buttons high, the FSM SHALL stay in IDLE and emit nothing.
REQ-014 In PRESS_DB, the counter SHALL increment each cycle while the candidate button is high and the other button is low.
REQ-015 In PRESS_DB, the FSM SHALL return to IDLE with no output if the candidate button drops or the other button rises.
REQ-016 When the PRESS_DB counter reaches DB_CYCLES-1 with the qualifying condition still true, the FSM SHALL enter HELD and assert `bit_valid` for exactly the next cycle.
REQ-017 On the cycle `bit_valid` asserts, `bit_val` SHALL equal the candidate and `hist` SHALL equal {hist[2:0], candidate}.
REQ-018 `bit_val` and `hist` SHALL hold their values until the next `bit_valid`.
REQ-019 Latency SHALL be fixed: if a raw button is high from rising edge E onward, `bit_valid` SHALL be high in the cycle beginning at edge E+DB_CYCLES+2.
REQ-020 In HELD, the FSM SHALL wait until both synchronised buttons are low, then clear the counter and enter REL_DB.
REQ-021 A held button SHALL never produce a second `bit_valid`.
REQ-022 In REL_DB, the counter SHALL increment while both synchronised buttons are low; any button high SHALL return the FSM to HELD.
REQ-023 In REL_DB, the FSM SHALL enter IDLE when the counter reaches DB_CYCLES-1.
REQ-024 The counter SHALL be ceil(log2(DB_CYCLES)) bits wide and SHALL never wrap, because every state exit clears it.
REQ-025 `hist` SHALL shift with no saturation; older bits drop out of hist[3].

Reset
REQ-026 While `rst` is high at a clock edge, the block SHALL set the FSM to IDLE and clear the counter, candidate, synchroniser flops, `bit_valid`, `bit_val`, `hist` and `busy` to 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no `bit_valid` emitted on or after the reset cycle.
REQ-028 A button held through reset release SHALL be treated as a new press and SHALL emit one `bit_valid` after the REQ-019 latency, measured from the first non-reset edge.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE=2'd0, PRESS_DB=2'd1, HELD=2'd2, REL_DB=2'd3) and the DB_CYCLES default constant.
REQ-030 The block SHALL use one sub-module, `btn_sync` (2-flop synchroniser with synchronous reset), instantiated once per button.
REQ-031 `bit_valid`, `bit_val`, `hist` and `busy` SHALL all be driven directly from flops.

Verification (DB_CYCLES=4)
REQ-032 Press test: btn1 high from edge 10 and held 20 cycles -> exactly one `bit_valid` in the cycle at edge 16, `bit_val`=1, `hist`=4'b0001; `busy` returns low 2+4 cycles after btn1 drops.
REQ-033 Bounce test: btn0 toggles high 2 cycles, low 1 cycle, repeated 5 times, then held high 10 cycles -> exactly one `bit_valid` with `bit_val`=0, and only after the stable run.
REQ-034 Simultaneous test: btn0 and btn1 rise on the same edge and are held 10 cycles -> no `bit_valid`; then btn1 alone -> one pulse with `bit_val`=1.
REQ-035 Sequence test: press 1,1,0,1,0 with full release between presses -> five pulses; final `hist`=4'b1010.
REQ-036 Reset test: `rst` pulsed while in PRESS_DB with the counter at 2 -> no pulse and all outputs 0; with btn1 still held after reset -> one pulse at edge (reset release)+6.
